// File: rtl/malloc_interval_tracker_pkg.sv
// Shared bounds-check definitions used by the malloc interval tracker and the
// object-bounds circular buffer: tracker states and address constants.
package malloc_interval_tracker_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    localparam logic [DEFAULT_XLEN-1:0] NULL_PTR = '0;
    localparam logic [DEFAULT_XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RET,
        EMIT
    } tracker_state_e;

endpackage

// File: rtl/malloc_interval_calc.sv
// Combinational interval end calculation: last = ptr + size - 1, saturating on
// carry out of XLEN bits, plus zero-size and NULL-pointer filter flags.
module malloc_interval_calc
    import malloc_interval_tracker_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] ptr,
    input  logic [XLEN-1:0] size,
    output logic [XLEN-1:0] last,
    output logic            zero_size,
    output logic            null_ptr
);

    logic [XLEN:0] sum;

    // The extra bit catches objects that run past the top of the address space.
    always_comb begin
        sum  = {1'b0, ptr} + {1'b0, size} - {{XLEN{1'b0}}, 1'b1};
        last = sum[XLEN] ? {XLEN{ALL_ONES[0]}} : sum[XLEN-1:0];
    end

    assign zero_size = (size == '0);
    assign null_ptr  = (ptr == XLEN'(NULL_PTR));

endmodule

// File: rtl/malloc_interval_tracker.sv
// Tracks malloc call/return pairs on the commit stream and emits one object
// interval per allocation. Optional call timeout: MALLOC_TRACKER_TIMEOUT_EN.
module malloc_interval_tracker
    import malloc_interval_tracker_pkg::*;
#(
`ifdef MALLOC_TRACKER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 4096,
`endif
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [XLEN-1:0] malloc_addr_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            commit_is_call_i,
    input  logic [XLEN-1:0] commit_target_i,
    input  logic [XLEN-1:0] a0_i,
`ifdef MALLOC_TRACKER_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic            en_write_o,
    output logic [XLEN-1:0] addr_first_o,
    output logic [XLEN-1:0] addr_last_o,
    output logic            busy_o
);

    tracker_state_e  state_q, state_d;
    logic [XLEN-1:0] size_q;
    logic [XLEN-1:0] ret_q;
    logic [XLEN-1:0] calc_last;
    logic            calc_zero_size;
    logic            calc_null_ptr;
    logic            trigger;
    logic            ret_hit;
    logic            capture;
    logic            go_emit;
`ifdef MALLOC_TRACKER_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]   timer_q;
    logic            timeout_hit;
`endif

    malloc_interval_calc #(
        .XLEN (XLEN)
    ) u_calc (
        .ptr       (a0_i),
        .size      (size_q),
        .last      (calc_last),
        .zero_size (calc_zero_size),
        .null_ptr  (calc_null_ptr)
    );

    assign trigger = commit_valid_i & commit_is_call_i & (commit_target_i == malloc_addr_i);
    assign ret_hit = commit_valid_i & (commit_pc_i == ret_q);
    assign busy_o  = (state_q == WAIT_RET);

    // EMIT behaves like IDLE for new calls so back-to-back allocations are not lost.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        go_emit = 1'b0;
`ifdef MALLOC_TRACKER_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE, EMIT: begin
                state_d = IDLE;
                if (trigger) begin
                    capture = 1'b1;
                    state_d = WAIT_RET;
                end
            end
            WAIT_RET: begin
                if (ret_hit) begin
                    if (!calc_zero_size && !calc_null_ptr) begin
                        go_emit = 1'b1;
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef MALLOC_TRACKER_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (!en_i) begin
            state_d = IDLE;
            capture = 1'b0;
            go_emit = 1'b0;
`ifdef MALLOC_TRACKER_TIMEOUT_EN
            timeout_hit = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            size_q       <= '0;
            ret_q        <= '0;
            en_write_o   <= 1'b0;
            addr_first_o <= '0;
            addr_last_o  <= '0;
        end else begin
            state_q    <= state_d;
            en_write_o <= go_emit;
            if (capture) begin
                size_q <= a0_i;
                ret_q  <= commit_pc_i + XLEN'(4);
            end
            if (go_emit) begin
                addr_first_o <= a0_i;
                addr_last_o  <= calc_last;
            end
        end
    end

`ifdef MALLOC_TRACKER_TIMEOUT_EN
    // The abort flag is sticky so software can notice a lost return later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q   <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (capture) begin
                timer_q <= '0;
            end else if (state_q == WAIT_RET) begin
                timer_q <= timer_q + TW'(1);
            end
            if (timeout_hit) begin
                timeout_o <= 1'b1;
            end
        end
    end
`endif

endmodule
